// File: rtl/cpu_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_ctrl
// Purpose  : Iteration sequencer for the LDPC check-processing phase; opens
//            one cpu_on window per iteration, drains, then awaits syndrome.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_phase_ctrl #(
    parameter int CPU_LEN    = 256,
    parameter int DRAIN_LEN  = 4,
    parameter int MAX_ITER   = 10,
    parameter int ITER_WIDTH = 4,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  syndrome_valid,
    input  logic                  syndrome_ok,
    output logic                  cpu_on,
    output logic                  cpu_first,
    output logic                  cpu_last,
    output logic [ITER_WIDTH-1:0] iter_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  success
);

    localparam logic [CNT_WIDTH-1:0]  c_run_last   = CNT_WIDTH'(CPU_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  c_drain_last = CNT_WIDTH'(DRAIN_LEN - 1);
    localparam logic [ITER_WIDTH-1:0] c_iter_last  = ITER_WIDTH'(MAX_ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_DRAIN    = 3'd2,
        S_WAIT_SYN = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_phase_cnt, w_phase_nxt;
    logic [ITER_WIDTH-1:0] r_iter_cnt, w_iter_nxt;
    logic                  r_success, w_success_nxt;
    logic                  r_cpu_on, r_cpu_first, r_cpu_last, r_busy, r_done;

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase_cnt;
        w_iter_nxt    = r_iter_cnt;
        w_success_nxt = r_success;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_RUN;
                    w_phase_nxt   = '0;
                    w_iter_nxt    = '0;
                    w_success_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt   = S_DONE;
                    w_success_nxt = 1'b0;
                end else if (r_phase_cnt == c_run_last) begin
                    w_state_nxt = S_DRAIN;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase_cnt + CNT_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_state_nxt   = S_DONE;
                    w_success_nxt = 1'b0;
                end else if (r_phase_cnt == c_drain_last) begin
                    w_state_nxt = S_WAIT_SYN;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase_cnt + CNT_WIDTH'(1);
                end
            end
            S_WAIT_SYN: begin
                // abort takes priority over a simultaneous verdict
                if (abort) begin
                    w_state_nxt   = S_DONE;
                    w_success_nxt = 1'b0;
                end else if (syndrome_valid) begin
                    if (syndrome_ok) begin
                        w_state_nxt   = S_DONE;
                        w_success_nxt = 1'b1;
                    end else if (r_iter_cnt == c_iter_last) begin
                        w_state_nxt   = S_DONE;
                        w_success_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_phase_nxt = '0;
                        w_iter_nxt  = r_iter_cnt + ITER_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= '0;
            r_iter_cnt  <= '0;
            r_success   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase_cnt <= w_phase_nxt;
            r_iter_cnt  <= w_iter_nxt;
            r_success   <= w_success_nxt;
        end
    end

    // Strobes are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_on    <= 1'b0;
            r_cpu_first <= 1'b0;
            r_cpu_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cpu_on    <= (w_state_nxt == S_RUN);
            r_cpu_first <= (w_state_nxt == S_RUN) && (w_phase_nxt == '0);
            r_cpu_last  <= (w_state_nxt == S_RUN) && (w_phase_nxt == c_run_last);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign cpu_on    = r_cpu_on;
    assign cpu_first = r_cpu_first;
    assign cpu_last  = r_cpu_last;
    assign iter_cnt  = r_iter_cnt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign success   = r_success;

endmodule
`default_nettype wire
